// File: rtl/apb_pwm_blinky_pkg.sv
// Shared register map and control-field layout for the APB multi-channel LED driver.
package apb_pwm_blinky_pkg;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] PERIOD_OFS = 4'h4;
  localparam logic [3:0] DUTY_OFS   = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_INV  = 2;
  localparam int CTRL_IE   = 3;

  localparam int CH_STRIDE = 'h10;

  typedef struct packed {
    logic ie;
    logic inv;
    logic mode;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/pwm_blinky_channel.sv
// One LED channel: shadowed period/duty, free-running counter, one-shot DONE and registered led.
module pwm_blinky_channel
  import apb_pwm_blinky_pkg::*;
#(
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 100000000,
  parameter int unsigned DEFAULT_DUTY   = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_we,
  input  logic             period_we,
  input  logic             duty_we,
  input  logic             status_we,
  input  logic [31:0]      wdata,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] period_shadow,
  output logic [CNT_W-1:0] duty_shadow,
  output logic [15:0]      cnt_hi,
  output logic             done,
  output logic             led
);

  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] per_sh_reg, duty_sh_reg;
  logic [CNT_W-1:0] per_act_reg, duty_act_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg, led_reg;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap, en_rise, raw;
  logic             unused_wdata;

  // A zero period behaves as a one-cycle period and produces no pulse.
  assign last_cnt = (per_act_reg == '0) ? '0 : per_act_reg - 1'b1;
  assign wrap     = ctrl_reg.en && (cnt_reg == last_cnt);
  assign en_rise  = ctrl_we && wdata[CTRL_EN] && !ctrl_reg.en;
  assign raw      = ctrl_reg.en && (per_act_reg != '0) && (cnt_reg < duty_act_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg     <= '0;
      per_sh_reg   <= CNT_W'(DEFAULT_PERIOD);
      duty_sh_reg  <= CNT_W'(DEFAULT_DUTY);
      per_act_reg  <= CNT_W'(DEFAULT_PERIOD);
      duty_act_reg <= CNT_W'(DEFAULT_DUTY);
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      led_reg      <= 1'b0;
    end else begin
      if (period_we) per_sh_reg  <= wdata[CNT_W-1:0];
      if (duty_we)   duty_sh_reg <= wdata[CNT_W-1:0];

      if (wrap || en_rise) begin
        per_act_reg  <= per_sh_reg;
        duty_act_reg <= duty_sh_reg;
      end

      if (!ctrl_reg.en || wrap || (ctrl_we && !wdata[CTRL_EN]))
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;

      // Software CTRL writes take priority over the one-shot auto-disable.
      if (ctrl_we)
        ctrl_reg <= ctrl_t'(wdata[3:0]);
      else if (wrap && ctrl_reg.mode)
        ctrl_reg.en <= 1'b0;

      if (wrap && ctrl_reg.mode)
        done_reg <= 1'b1;
      else if (status_we && wdata[0])
        done_reg <= 1'b0;

      led_reg <= raw ^ ctrl_reg.inv;
    end
  end

  generate
    if (CNT_W >= 16) begin : g_cnt_hi
      assign cnt_hi = cnt_reg[CNT_W-1 -: 16];
    end else begin : g_cnt_short
      assign cnt_hi = {cnt_reg, {(16-CNT_W){1'b0}}};
    end
  endgenerate

  assign ctrl          = ctrl_reg;
  assign period_shadow = per_sh_reg;
  assign duty_shadow   = duty_sh_reg;
  assign done          = done_reg;
  assign led           = led_reg;
  assign unused_wdata  = ^wdata;

endmodule

// File: rtl/apb_pwm_blinky.sv
// APB front end for NUM_CH LED channels: address decode, registered read mux, slave error and irq.
module apb_pwm_blinky
  import apb_pwm_blinky_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 100000000,
  parameter int unsigned DEFAULT_DUTY   = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] led,
  output logic              irq
);

  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

  logic [3:0]       ch_sel, reg_ofs;
  logic             mapped, wr_en;
  logic [31:0]      rd_data;
  logic [31:0]      prdata_reg;
  logic             pready_reg, pslverr_reg, irq_reg;
  logic [3:0]       ctrl_q     [NUM_CH];
  logic [CNT_W-1:0] per_q      [NUM_CH];
  logic [CNT_W-1:0] duty_q     [NUM_CH];
  logic [15:0]      cnt_hi_q   [NUM_CH];
  logic [NUM_CH-1:0] done_v, ie_v;
  logic             unused_paddr;

  // Channels sit on a CH_STRIDE grid; byte lanes and bits above [7:0] are ignored.
  assign ch_sel       = paddr[7:4];
  assign reg_ofs      = {paddr[3:2], 2'b00};
  assign mapped       = {1'b0, ch_sel} < NUM_CH_L;
  assign wr_en        = psel && penable && pwrite && mapped;
  assign unused_paddr = ^{paddr[31:8], paddr[1:0]};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_sel == 4'(gi));

    pwm_blinky_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_DUTY   (DEFAULT_DUTY)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .ctrl_we       (hit && (reg_ofs == CTRL_OFS)),
      .period_we     (hit && (reg_ofs == PERIOD_OFS)),
      .duty_we       (hit && (reg_ofs == DUTY_OFS)),
      .status_we     (hit && (reg_ofs == STATUS_OFS)),
      .wdata         (pwdata),
      .ctrl          (ctrl_q[gi]),
      .period_shadow (per_q[gi]),
      .duty_shadow   (duty_q[gi]),
      .cnt_hi        (cnt_hi_q[gi]),
      .done          (done_v[gi]),
      .led           (led[gi])
    );

    assign ie_v[gi] = ctrl_q[gi][CTRL_IE];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 4'(i)) begin
        case (reg_ofs)
          CTRL_OFS:   rd_data = {28'd0, ctrl_q[i]};
          PERIOD_OFS: rd_data = 32'(per_q[i]);
          DUTY_OFS:   rd_data = 32'(duty_q[i]);
          STATUS_OFS: rd_data = {cnt_hi_q[i], 15'd0, done_v[i]};
          default:    rd_data = '0;
        endcase
      end
    end
  end

  // Registering in the setup phase makes read data and error valid in the access phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      prdata_reg  <= rd_data;
      pready_reg  <= 1'b1;
      pslverr_reg <= psel && !penable && !mapped;
      irq_reg     <= |(done_v & ie_v);
    end
  end

  assign prdata  = prdata_reg;
  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_apb_pwm_blinky.sv
// Directed plus randomized APB traffic against a cycle-level behavioural model of the LED driver.
module tb_apb_pwm_blinky;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int unsigned DEF_P  = 100000000;
  localparam int unsigned DEF_D  = 50000000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       paddr = '0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr, irq;
  logic [NUM_CH-1:0] led;

  apb_pwm_blinky #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEF_P),
    .DEFAULT_DUTY   (DEF_D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .led     (led),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  logic [NUM_CH-1:0] led_log [0:4095];

  // Model state: programmed registers plus position inside the current period.
  logic              m_en [NUM_CH], m_mode [NUM_CH], m_inv [NUM_CH], m_ie [NUM_CH], m_done [NUM_CH];
  logic [31:0]       m_sh_per [NUM_CH], m_sh_duty [NUM_CH], m_act_per [NUM_CH], m_act_duty [NUM_CH];
  logic [31:0]       m_pos [NUM_CH];
  logic [NUM_CH-1:0] m_led;
  logic              m_irq, m_pready, m_pslverr;
  logic [31:0]       m_prdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ch;
    logic [31:0] r;
    ch = int'(a[7:4]);
    r = '0;
    if (ch < NUM_CH) begin
      case (a[3:2])
        2'd0: r = {28'd0, m_ie[ch], m_inv[ch], m_mode[ch], m_en[ch]};
        2'd1: r = m_sh_per[ch];
        2'd2: r = m_sh_duty[ch];
        default: r = {m_pos[ch][31:16], 15'd0, m_done[ch]};
      endcase
    end
    return r;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_en[c] = 0; m_mode[c] = 0; m_inv[c] = 0; m_ie[c] = 0; m_done[c] = 0;
        m_sh_per[c] = DEF_P; m_sh_duty[c] = DEF_D; m_act_per[c] = DEF_P; m_act_duty[c] = DEF_D;
        m_pos[c] = 0;
      end
      m_led = '0; m_irq = 0; m_pready = 0; m_pslverr = 0; m_prdata = '0;
    end else begin
      m_prdata  = model_read(paddr);
      m_pslverr = psel && !penable && (int'(paddr[7:4]) >= NUM_CH);
      m_pready  = 1;
      m_irq     = 0;
      for (int c = 0; c < NUM_CH; c++) m_irq = m_irq | (m_done[c] & m_ie[c]);
      for (int c = 0; c < NUM_CH; c++) begin
        longint len;
        bit wr, period_end, set_done, was_en;
        logic [31:0] sh_p, sh_d;
        // High for the first 'duty' cycles of each period; an empty period never lights.
        m_led[c] = (m_en[c] && m_act_per[c] != 0 && m_pos[c] < m_act_duty[c]) ^ m_inv[c];
        wr = psel && penable && pwrite && (int'(paddr[7:4]) == c);
        len = (m_act_per[c] == 0) ? 1 : longint'(m_act_per[c]);
        period_end = m_en[c] && (longint'(m_pos[c]) + 1 == len);
        was_en = m_en[c]; sh_p = m_sh_per[c]; sh_d = m_sh_duty[c];
        set_done = 0;
        if (m_en[c]) m_pos[c] = period_end ? 0 : m_pos[c] + 1;
        if (period_end) begin
          m_act_per[c] = sh_p; m_act_duty[c] = sh_d;
          if (m_mode[c]) begin m_done[c] = 1; m_en[c] = 0; set_done = 1; end
        end
        if (wr && paddr[3:2] == 2'd0) begin
          if (pwdata[0] && !was_en) begin m_act_per[c] = sh_p; m_act_duty[c] = sh_d; m_pos[c] = 0; end
          if (!pwdata[0]) m_pos[c] = 0;
          m_en[c] = pwdata[0]; m_mode[c] = pwdata[1]; m_inv[c] = pwdata[2]; m_ie[c] = pwdata[3];
        end
        if (wr && paddr[3:2] == 2'd1) m_sh_per[c] = pwdata;
        if (wr && paddr[3:2] == 2'd2) m_sh_duty[c] = pwdata;
        if (wr && paddr[3:2] == 2'd3 && pwdata[0] && !set_done) m_done[c] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    chk_on = 1'b1;
    #1;
    cyc++;
    led_log[cyc % 4096] = led;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1; psel = 1; penable = 0;
    tick();
    penable = 1;
    tick();
    psel = 0; penable = 0; pwrite = 0;
    $display("apb wr addr=0x%08h data=0x%08h", a, d);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    paddr = a; pwrite = 0; psel = 1; penable = 0;
    tick();
    penable = 1;
    d = prdata; err = pslverr;
    tick();
    psel = 0; penable = 0;
    $display("apb rd addr=0x%08h data=0x%08h err=%0d", a, d, err);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("led", 32'(led), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      check("pready", 32'(pready), 32'(m_pready));
      check("pslverr", 32'(pslverr), 32'(m_pslverr));
      if (psel && penable && !pwrite) check("prdata", prdata, m_prdata);
    end
  end

  initial begin
    logic [31:0] rd;
    logic err;
    int e0, e1;

    rst_n = 0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    rst_n = 1;
    tick();
    check("pready_after_rst", 32'(pready), 32'h1);
    apb_read(32'h04, rd, err); check("rst_period", rd, DEF_P);
    apb_read(32'h08, rd, err); check("rst_duty", rd, DEF_D);

    // Continuous PWM on ch1, then invert without restarting the counter.
    apb_write(32'h14, 10); apb_write(32'h18, 3); apb_write(32'h10, 32'h1);
    e0 = cyc;
    repeat (20) tick();
    for (int k = 0; k < 20; k++) check("pwm_led1", 32'(led_log[(e0 + 1 + k) % 4096][1]), 32'((k % 10) < 3));
    apb_write(32'h10, 32'h5);
    e1 = cyc;
    repeat (12) tick();
    for (int e = e1 + 1; e <= e1 + 12; e++)
      check("pwm_inv_led1", 32'(led_log[e % 4096][1]), 32'(!(((e - e0 - 1) % 10) < 3)));
    apb_write(32'h10, 32'h0);

    // Duty change mid-period lands at the next wrap.
    apb_write(32'h04, 8); apb_write(32'h08, 4); apb_write(32'h00, 32'h1);
    e0 = cyc;
    apb_write(32'h08, 6);
    repeat (16) tick();
    for (int k = 0; k < 16; k++)
      check("shadow_led0", 32'(led_log[(e0 + 1 + k) % 4096][0]), 32'((k % 8) < (k < 8 ? 4 : 6)));
    apb_write(32'h00, 32'h0);

    // One-shot with interrupt on ch2.
    apb_write(32'h24, 5); apb_write(32'h28, 2); apb_write(32'h20, 32'hB);
    e0 = cyc;
    repeat (10) tick();
    for (int k = 0; k < 10; k++) check("oneshot_led2", 32'(led_log[(e0 + 1 + k) % 4096][2]), 32'(k < 2));
    check("oneshot_irq", 32'(irq), 32'h1);
    apb_read(32'h20, rd, err); check("oneshot_ctrl", rd, 32'hA);
    apb_read(32'h2C, rd, err); check("oneshot_status", rd, 32'h1);
    apb_write(32'h2C, 32'h1);
    check("irq_hold", 32'(irq), 32'h1);
    tick();
    check("irq_clear", 32'(irq), 32'h0);

    // Edge values on ch3: empty period, zero duty, full duty.
    apb_write(32'h34, 0); apb_write(32'h38, 3); apb_write(32'h30, 32'h1);
    e0 = cyc;
    repeat (6) tick();
    for (int k = 0; k < 6; k++) check("per0_led3", 32'(led_log[(e0 + 1 + k) % 4096][3]), 32'h0);
    apb_write(32'h30, 32'h0); apb_write(32'h34, 4); apb_write(32'h38, 0); apb_write(32'h30, 32'h1);
    e0 = cyc;
    repeat (8) tick();
    for (int k = 0; k < 8; k++) check("duty0_led3", 32'(led_log[(e0 + 1 + k) % 4096][3]), 32'h0);
    apb_write(32'h30, 32'h0); apb_write(32'h38, 4); apb_write(32'h30, 32'h1);
    e0 = cyc;
    repeat (8) tick();
    for (int k = 0; k < 8; k++) check("dutyfull_led3", 32'(led_log[(e0 + 1 + k) % 4096][3]), 32'h1);
    apb_write(32'h30, 32'h0);

    // Unmapped window.
    apb_read(32'h40, rd, err);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_pslverr", 32'(err), 32'h1);
    apb_write(32'h40, 32'hFFFF_FFFF);
    apb_write(32'h44, 32'h0000_0001);
    apb_read(32'h04, rd, err);
    check("ch0_period_kept", rd, 32'd8);
    check("mapped_pslverr", 32'(err), 32'h0);
    apb_read(32'h00, rd, err); check("ch0_ctrl_kept", rd, 32'h0);

    // Randomized traffic; the per-cycle compare carries the checking.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a, d;
      int chn;
      a = $urandom;
      chn = $urandom_range(0, 5);
      if (chn >= NUM_CH) chn = $urandom_range(NUM_CH, 15);
      a[7:4] = 4'(chn);
      case (a[3:2])
        2'd1, 2'd2: d = $urandom_range(0, 12);
        default:    d = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) apb_read(a, rd, err);
      else apb_write(a, d);
      repeat ($urandom_range(0, 8)) tick();
    end

    // Reset in the middle of a running period.
    apb_write(32'h14, 10); apb_write(32'h18, 3); apb_write(32'h10, 32'h5);
    repeat (4) tick();
    rst_n = 0;
    tick();
    check("midrst_led", 32'(led), 32'h0);
    rst_n = 1;
    tick();
    apb_read(32'h14, rd, err); check("midrst_period", rd, DEF_P);
    apb_read(32'h10, rd, err); check("midrst_ctrl", rd, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/apb_pwm_blinky.md
Name: apb_pwm_blinky

Overview:
- Multi-channel, APB-programmable LED driver. It is the next generation of the single fixed-mode blinker.
- Each of NUM_CH channels has its own period, duty, enable, polarity and mode (continuous PWM/blink or one-shot).
- Sits on the processor APB bus alongside other peripherals and drives board LEDs directly.

Parameters:
- NUM_CH, 4: number of independent LED channels, 1..16.
- CNT_W, 32: width of the period, duty and counter fields, 8..32.
- DEFAULT_PERIOD, 100000000: reset value of every channel's PERIOD.
- DEFAULT_DUTY, 50000000: reset value of every channel's DUTY.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- paddr  in  32  APB address; only [7:0] decoded
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- led  out  NUM_CH  per-channel LED outputs
- irq  out  1  level interrupt, OR of (DONE & IE) over all channels

Behaviour:
- Reset and clocking:
  - Clock clk. Reset rst_n is synchronous and active-low.
  - Reset values: prdata=0, pready=0, pslverr=0, led=0, irq=0.
  - Reset values for every channel: CTRL=0, PERIOD=DEFAULT_PERIOD, DUTY=DEFAULT_DUTY, cnt=0, DONE=0.
- Address map:
  - Channel i base = 0x10*i.
  - +0x0 CTRL RW: bit0 EN, bit1 MODE (0 continuous, 1 one-shot), bit2 INV, bit3 IE.
  - +0x4 PERIOD RW.
  - +0x8 DUTY RW.
  - +0xC STATUS: bit0 DONE, write-1-to-clear; bits[31:16]=cnt[CNT_W-1:CNT_W-16] read-only.
  - paddr[1:0] is ignored.
- APB protocol:
  - pready is registered and goes to 1 the cycle after reset deasserts, then stays at 1: zero wait states.
  - Write commits on psel & penable & pwrite.
  - prdata is registered every cycle from the current paddr decode, so it is valid in the access phase.
  - Unmapped addresses (channel index >= NUM_CH, or paddr[7:0] >= 0x10*NUM_CH) read as 0.
  - pslverr=1 during an access phase (psel & penable) to an unmapped address, otherwise 0. Writes to unmapped addresses are ignored.
  - Register fields narrower than 32 bits read zero-extended; upper bits are ignored on write.
- Shadowing:
  - PERIOD and DUTY writes go to shadow registers.
  - Active copies load from the shadows when cnt wraps to 0, or when EN goes 0→1. This gives glitch-free retiming.
- Channel counter, while EN=1:
  - cnt increments each cycle.
  - When cnt == active_period-1, cnt wraps to 0.
  - active_period==0 is treated as 1, so cnt is held at 0.
- LED output:
  - raw = (cnt < active_duty). duty >= period gives constant on; duty 0 gives constant off.
  - led[i] is registered: raw ^ INV, one cycle latency from cnt.
- Disabled channel (EN=0): cnt=0 and led[i]=INV.
- One-shot mode (MODE=1):
  - At the wrap that ends the first full period, hardware clears EN and sets DONE. led then reverts to INV.
- Continuous mode: DONE is never set.
- Simultaneous events:
  - A software write to CTRL in the same cycle as the hardware EN-clear: the software write wins.
  - DONE being set and a W1C in the same cycle: set wins.
  - Writing EN=1 while EN is already 1 does not restart the counter.
- irq is registered: one cycle after DONE&IE changes.
- Reset asserted mid-period: every register returns to its reset value on that clock edge and led goes to 0 immediately.

Decomposition:
- Package apb_pwm_blinky_pkg holds:
  - Register offsets: CTRL_OFS=0x0, PERIOD_OFS=0x4, DUTY_OFS=0x8, STATUS_OFS=0xC.
  - CTRL bit positions: EN, MODE, INV, IE.
  - CH_STRIDE=0x10.
- Sub-module pwm_blinky_channel (one per channel, generate loop):
  - Owns the shadow and active period/duty, cnt, the one-shot logic, DONE and led.
- Top level owns APB decode, prdata mux, pslverr and the irq OR.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks → led=0, pready=0; read ch0 PERIOD → DEFAULT_PERIOD; read ch0 DUTY → DEFAULT_DUTY; pready=1 from the first cycle after release.
- PWM: ch1 PERIOD=10, DUTY=3, CTRL=EN → led[1] high 3 cycles, low 7, repeating; INV=1 inverts the pattern.
- Shadow: ch0 running PERIOD=8, write DUTY=6 mid-period → current period keeps the old duty, new duty takes effect from the next wrap.
- One-shot: ch2 PERIOD=5, DUTY=2, CTRL=EN|MODE|IE → one 2-high/3-low pulse, then EN reads 0, STATUS.DONE=1, irq=1; write STATUS=1 → irq=0 one cycle later.
- Edge values: PERIOD=0 or DUTY=0 → led constant off; DUTY=PERIOD=4 → led constant on.
- Errors: read address 0x10*NUM_CH → prdata=0, pslverr=1 in the access phase; write there → no register changes.
